regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between NREQ writeback sources (ALU, load unit, CSR unit).

---
 rtl/regfile_wb_pkg.sv | 16 +
 rtl/wb_rr_arbiter.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Imported by wb_rr_arbiter and regfile_wb_arbiter.
package regfile_wb_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Request vector to one-hot grant; grant is forced to zero while reset_i is high.
// REGFILE_WB_RR_EN defined: round-robin with a pointer flop; undefined: fixed priority, lowest index wins.
module wb_rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o
);
    import regfile_wb_pkg::*;

    logic [NREQ-1:0] gnt;
    logic            found;

`ifdef REGFILE_WB_RR_EN
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Rank each requester by its distance from the pointer and grant the nearest one.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_i[i] && (((i + NREQ - int'(ptr_q)) % NREQ) == k)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_o[i]) begin
                ptr_d = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unusedClk;
    assign unusedClk = clk_i;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_i[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    assign gnt_o = reset_i ? '0 : gnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback sources and tracks per-register busy bits.
// Grant policy selected by REGFILE_WB_RR_EN (round-robin when defined, fixed priority otherwise).
module regfile_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int XLEN  = regfile_wb_pkg::XLEN,
    parameter int NREGS = regfile_wb_pkg::NREGS
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [NREQ-1:0]                          req_valid_i,
    input  logic [NREQ*regfile_wb_pkg::REG_IDX_W-1:0] req_rd_i,
    input  logic [NREQ*XLEN-1:0]                     req_data_i,
    output logic [NREQ-1:0]                          req_ready_o,
    input  logic                                     rsv_valid_i,
    input  logic [regfile_wb_pkg::REG_IDX_W-1:0]     rsv_rd_i,
    output logic [NREGS-1:0]                         busy_o,
    output logic                                     rf_write_o,
    output logic [regfile_wb_pkg::REG_IDX_W-1:0]     rf_write_reg_o,
    output logic [XLEN-1:0]                          rf_write_data_o
);
    import regfile_wb_pkg::*;

    logic [NREQ-1:0]  xfer;
    logic             anyXfer;
    reg_idx_t         selRd;
    logic [XLEN-1:0]  selData;

    logic             rfWrite_q, rfWrite_d;
    reg_idx_t         rfReg_q, rfReg_d;
    logic [XLEN-1:0]  rfData_q, rfData_d;
    logic [NREGS-1:0] busy_q, busy_d;

    wb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .req_i   (req_valid_i),
        .gnt_o   (req_ready_o)
    );

    assign xfer    = req_valid_i & req_ready_o;
    assign anyXfer = |xfer;

    always_comb begin
        selRd   = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer[i]) begin
                selRd   = req_rd_i[i*REG_IDX_W +: REG_IDX_W];
                selData = req_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Writes to x0 still update index/data but never raise the write enable.
    always_comb begin
        rfWrite_d = anyXfer && (selRd != '0);
        rfReg_d   = anyXfer ? selRd   : rfReg_q;
        rfData_d  = anyXfer ? selData : rfData_q;
    end

    // Release first, then reserve, so a same-cycle reservation of the same register survives.
    always_comb begin
        busy_d = busy_q;
        if (anyXfer && (selRd != '0)) begin
            busy_d[selRd] = 1'b0;
        end
        if (rsv_valid_i && (rsv_rd_i != '0)) begin
            busy_d[rsv_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rfWrite_q <= 1'b0;
            rfReg_q   <= '0;
            rfData_q  <= '0;
            busy_q    <= '0;
        end else begin
            rfWrite_q <= rfWrite_d;
            rfReg_q   <= rfReg_d;
            rfData_q  <= rfData_d;
            busy_q    <= busy_d;
        end
    end

    assign rf_write_o      = rfWrite_q;
    assign rf_write_reg_o  = rfReg_q;
    assign rf_write_data_o = rfData_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand sequences, randomized traffic vs reference model.
// Expectations for contended grants follow REGFILE_WB_RR_EN.
module tb_regfile_wb_arbiter;

    localparam int NREQ  = 3;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [2:0]  req_valid_i;
    logic [14:0] req_rd_i;
    logic [95:0] req_data_i;
    logic [2:0]  req_ready_o;
    logic        rsv_valid_i;
    logic [4:0]  rsv_rd_i;
    logic [31:0] busy_o;
    logic        rf_write_o;
    logic [4:0]  rf_write_reg_o;
    logic [31:0] rf_write_data_o;

    int          checks = 0;
    int          failures = 0;
    logic [2:0]  readySample;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] rd;
        logic [95:0] data;
        logic        rsvValid;
        logic [4:0]  rsvRd;
        logic [2:0]  expReady;
        logic        expWrite;
        logic [4:0]  expReg;
        logic [31:0] expData;
        logic [31:0] expBusy;
    } vec_t;

    vec_t vecs[12];

    regfile_wb_arbiter #(
        .NREQ  (NREQ),
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid_i),
        .req_rd_i        (req_rd_i),
        .req_data_i      (req_data_i),
        .req_ready_o     (req_ready_o),
        .rsv_valid_i     (rsv_valid_i),
        .rsv_rd_i        (rsv_rd_i),
        .busy_o          (busy_o),
        .rf_write_o      (rf_write_o),
        .rf_write_reg_o  (rf_write_reg_o),
        .rf_write_data_o (rf_write_data_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mkVec(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                                   input logic rv, input logic [4:0] rr, input logic [2:0] er,
                                   input logic ew, input logic [4:0] eReg, input logic [31:0] eData,
                                   input logic [31:0] eBusy);
        vec_t t;
        t.valid = v;   t.rd = rd;     t.data = d;
        t.rsvValid = rv; t.rsvRd = rr; t.expReady = er;
        t.expWrite = ew; t.expReg = eReg; t.expData = eData; t.expBusy = eBusy;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, capture combinational ready mid-cycle, return 1ns after the edge.
    task automatic applyStimulus(input logic [2:0] v, input logic [14:0] rd, input logic [95:0] d,
                                 input logic rv, input logic [4:0] rr);
        req_valid_i = v;
        req_rd_i    = rd;
        req_data_i  = d;
        rsv_valid_i = rv;
        rsv_rd_i    = rr;
        #2;
        readySample = req_ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        reset_i     = 1'b1;
        req_valid_i = 3'b111;
        req_rd_i    = {5'd3, 5'd2, 5'd1};
        req_data_i  = {32'h3, 32'h2, 32'h1};
        rsv_valid_i = 1'b1;
        rsv_rd_i    = 5'd4;
        #1;
        checkOutput("reset_ready_async", {29'd0, req_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput("reset_write", {31'd0, rf_write_o}, 32'd0);
        checkOutput("reset_reg", {27'd0, rf_write_reg_o}, 32'd0);
        checkOutput("reset_data", rf_write_data_o, 32'd0);
        checkOutput("reset_busy", busy_o, 32'd0);
        checkOutput("reset_ready", {29'd0, req_ready_o}, 32'd0);
        req_valid_i = '0;
        rsv_valid_i = 1'b0;
        reset_i     = 1'b0;
    endtask

    // Reference model state for randomized traffic.
    bit          pend[3];
    logic [4:0]  pRd[3];
    logic [31:0] pData[3];
    logic [31:0] mBusy;
    int          mPtr;
    logic [4:0]  mReg;
    logic [31:0] mData;

    initial begin
        logic [2:0]  expGnt;
        logic [14:0] rdVec;
        logic [95:0] dataVec;
        logic [2:0]  vVec;
        logic        rv;
        logic [4:0]  rr;
        int          g;
        int          idx;

        vecs[0]  = mkVec(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0,
                         3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
        vecs[1]  = mkVec(3'b000, '0, '0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0);
        vecs[2]  = mkVec(3'b000, '0, '0, 1'b1, 5'd7, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0080);
        vecs[3]  = mkVec(3'b000, '0, '0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0080);
        vecs[4]  = mkVec(3'b000, '0, '0, 1'b0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0080);
        vecs[5]  = mkVec(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 1'b0, 5'd0,
                         3'b010, 1'b1, 5'd7, 32'h77, 32'h0);
        vecs[6]  = mkVec(3'b000, '0, '0, 1'b1, 5'd9, 3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0200);
        vecs[7]  = mkVec(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b1, 5'd9,
                         3'b100, 1'b1, 5'd9, 32'h99, 32'h0000_0200);
        vecs[8]  = mkVec(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b1, 5'd0,
                         3'b001, 1'b0, 5'd0, 32'h1234, 32'h0000_0200);
        vecs[9]  = mkVec(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'hA, 32'h0}, 1'b0, 5'd0,
                         3'b010, 1'b1, 5'd9, 32'hA, 32'h0);
        vecs[10] = mkVec(3'b100, {5'd3, 5'd0, 5'd0}, {32'h33, 32'h0, 32'h0}, 1'b0, 5'd0,
                         3'b100, 1'b1, 5'd3, 32'h33, 32'h0);
        vecs[11] = mkVec(3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h44}, 1'b0, 5'd0,
                         3'b001, 1'b1, 5'd4, 32'h44, 32'h0);

        doReset();

        for (int n = 0; n < 12; n++) begin
            applyStimulus(vecs[n].valid, vecs[n].rd, vecs[n].data, vecs[n].rsvValid, vecs[n].rsvRd);
            checkOutput($sformatf("vec%0d_ready", n), {29'd0, readySample}, {29'd0, vecs[n].expReady});
            checkOutput($sformatf("vec%0d_write", n), {31'd0, rf_write_o}, {31'd0, vecs[n].expWrite});
            checkOutput($sformatf("vec%0d_busy", n), busy_o, vecs[n].expBusy);
            if (vecs[n].expReady != 3'b000) begin
                checkOutput($sformatf("vec%0d_reg", n), {27'd0, rf_write_reg_o}, {27'd0, vecs[n].expReg});
                checkOutput($sformatf("vec%0d_data", n), rf_write_data_o, vecs[n].expData);
            end
        end

        // Contention: all three requesters valid for six cycles.
        doReset();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hC2, 32'hC1}, 1'b0, 5'd0);
`ifdef REGFILE_WB_RR_EN
            expGnt = 3'b001 << (c % 3);
`else
            expGnt = 3'b001;
`endif
            checkOutput($sformatf("contend%0d_ready", c), {29'd0, readySample}, {29'd0, expGnt});
            checkOutput($sformatf("contend%0d_write", c), {31'd0, rf_write_o}, 32'd1);
            checkOutput($sformatf("contend%0d_reg", c), {27'd0, rf_write_reg_o},
                        (expGnt == 3'b001) ? 32'd1 : (expGnt == 3'b010) ? 32'd2 : 32'd3);
        end

        // Asynchronous reset while a write is on the port.
        doReset();
        applyStimulus(3'b000, '0, '0, 1'b1, 5'd6);
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h55}, 1'b0, 5'd0);
        checkOutput("async_pre_write", {31'd0, rf_write_o}, 32'd1);
        checkOutput("async_pre_busy", busy_o, 32'h0000_0040);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("async_write", {31'd0, rf_write_o}, 32'd0);
        checkOutput("async_busy", busy_o, 32'd0);
        checkOutput("async_data", rf_write_data_o, 32'd0);
        checkOutput("async_reg", {27'd0, rf_write_reg_o}, 32'd0);
        checkOutput("async_ready", {29'd0, req_ready_o}, 32'd0);

        // Randomized traffic against the reference model.
        doReset();
        mBusy = '0;
        mPtr  = 0;
        mReg  = '0;
        mData = '0;
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(1) == 1)) begin
                    pend[i]  = 1'b1;
                    pRd[i]   = 5'($urandom_range(31));
                    pData[i] = $urandom;
                end
            end
            rv = ($urandom_range(9) < 3);
            rr = 5'($urandom_range(31));
            for (int i = 0; i < 3; i++) begin
                vVec[i]             = pend[i];
                rdVec[i*5 +: 5]     = pend[i] ? pRd[i] : 5'd0;
                dataVec[i*32 +: 32] = pend[i] ? pData[i] : 32'd0;
            end

            g = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (mPtr + k) % 3;
                if (g < 0 && pend[idx]) g = idx;
            end
            expGnt = (g < 0) ? 3'b000 : (3'b001 << g);

            applyStimulus(vVec, rdVec, dataVec, rv, rr);
            checkOutput($sformatf("rand%0d_ready", cyc), {29'd0, readySample}, {29'd0, expGnt});

            if (g >= 0) begin
                mReg  = pRd[g];
                mData = pData[g];
                if (pRd[g] != 5'd0) mBusy[pRd[g]] = 1'b0;
                pend[g] = 1'b0;
`ifdef REGFILE_WB_RR_EN
                mPtr = (g + 1) % 3;
`endif
            end
            if (rv && rr != 5'd0) mBusy[rr] = 1'b1;

            checkOutput($sformatf("rand%0d_write", cyc), {31'd0, rf_write_o},
                        {31'd0, (g >= 0) && (mReg != 5'd0)});
            checkOutput($sformatf("rand%0d_busy", cyc), busy_o, mBusy);
            if (g >= 0) begin
                checkOutput($sformatf("rand%0d_reg", cyc), {27'd0, rf_write_reg_o}, {27'd0, mReg});
                checkOutput($sformatf("rand%0d_data", cyc), rf_write_data_o, mData);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
